// File: rtl/mmreq_pkg.sv
// Shared definitions for the Xillybus mmreq/mmresp register bridge:
// header/status bit positions, FSM state encoding and the timeout read value.
package mmreq_pkg;

   localparam int unsigned RNW_BIT  = 31;
   localparam int unsigned TMO_BIT  = 30;
   localparam int unsigned ADDR_LSB = 0;
   localparam int unsigned ADDR_MSB = 23;

   localparam logic [31:0] TIMEOUT_DATA_DFLT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_BUS,
      ST_RESP0,
      ST_RESP1
   } mmreq_state_e;

endpackage

// File: rtl/xil_mmreq_bridge.sv
// mmreq header/data word pairs -> single-outstanding register bus access -> two mmresp words.
// Optional bus timeout enabled by defining MMREQ_TIMEOUT_EN.
module xil_mmreq_bridge
   import mmreq_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 24,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] TIMEOUT_DATA   = TIMEOUT_DATA_DFLT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           mmreq_data,
   input  logic                  mmreq_wren,
   output logic                  mmreq_full,
   input  logic                  mmreq_open,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [31:0]           bus_wdata,
   output logic                  bus_en,
   output logic                  bus_wr,
   input  logic                  bus_ack,
   input  logic [31:0]           bus_rdata,
   output logic [31:0]           resp_data,
   output logic                  resp_wr,
   input  logic                  resp_full,
   output logic                  busy
);

   localparam int unsigned AFW = ADDR_MSB - ADDR_LSB + 1;

   mmreq_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           word1_q, word1_d;
   logic                  rnw_q, rnw_d;
   logic                  tmo_q, tmo_d;
   logic                  tmo_hit;
   logic [31:0]           word0;

`ifdef MMREQ_TIMEOUT_EN
   logic [31:0] cnt_q, cnt_d;

   // Counter sits at zero outside BUS, so it is already cleared on BUS entry.
   always_comb begin
      cnt_d = '0;
      if (state_q == ST_BUS) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tmo_hit = (state_q == ST_BUS) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      word0                   = '0;
      word0[RNW_BIT]          = rnw_q;
      word0[TMO_BIT]          = tmo_q;
      word0[ADDR_MSB:ADDR_LSB] = AFW'(addr_q);
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word1_d = word1_q;
      rnw_d   = rnw_q;
      tmo_d   = tmo_q;

      bus_en     = 1'b0;
      bus_wr     = 1'b0;
      resp_wr    = 1'b0;
      resp_data  = '0;
      busy       = (state_q != ST_IDLE);
      mmreq_full = rst;

      case (state_q)
         ST_IDLE: begin
            if (mmreq_wren) begin
               rnw_d   = mmreq_data[RNW_BIT];
               addr_d  = mmreq_data[ADDR_WIDTH-1:0];
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
            // A closed device file drops the half-received request.
            if (!mmreq_open) begin
               state_d = ST_IDLE;
            end else if (mmreq_wren) begin
               wdata_d = mmreq_data;
               state_d = ST_BUS;
            end
         end
         ST_BUS: begin
            bus_en     = 1'b1;
            bus_wr     = !rnw_q;
            mmreq_full = 1'b1;
            if (bus_ack) begin
               word1_d = rnw_q ? bus_rdata : wdata_q;
               tmo_d   = 1'b0;
               state_d = ST_RESP0;
            end else if (tmo_hit) begin
               word1_d = TIMEOUT_DATA;
               tmo_d   = 1'b1;
               state_d = ST_RESP0;
            end
         end
         ST_RESP0: begin
            mmreq_full = 1'b1;
            resp_data  = word0;
            if (!resp_full) begin
               resp_wr = 1'b1;
               state_d = ST_RESP1;
            end
         end
         ST_RESP1: begin
            mmreq_full = 1'b1;
            resp_data  = word1_q;
            if (!resp_full) begin
               resp_wr = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         word1_q <= '0;
         rnw_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word1_q <= word1_d;
         rnw_q   <= rnw_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_xil_mmreq_bridge.sv
// Self-checking bench for xil_mmreq_bridge; timeout scenario depends on MMREQ_TIMEOUT_EN.
module tb_xil_mmreq_bridge;

   localparam int unsigned AW   = 16;
   localparam int unsigned TMO  = 8;
   localparam logic [31:0] TDAT = 32'hFFFF_FFFF;
   localparam logic [31:0] AMASK = (32'h1 << AW) - 32'h1;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   mmreq_data;
   logic          mmreq_wren;
   logic          mmreq_full;
   logic          mmreq_open;
   logic [AW-1:0] bus_addr;
   logic [31:0]   bus_wdata;
   logic          bus_en;
   logic          bus_wr;
   logic          bus_ack;
   logic [31:0]   bus_rdata;
   logic [31:0]   resp_data;
   logic          resp_wr;
   logic          resp_full;
   logic          busy;

   int tests_run    = 0;
   int tests_failed = 0;

   int            cyc = 0;
   int            en_cycles = 0;
   int            full_viol = 0;
   int            stab_err = 0;
   logic          prev_en = 1'b0;
   logic [AW-1:0] p_addr = '0;
   logic [31:0]   p_wdata = '0;
   logic          p_wr = 1'b0;
   logic [31:0]   resp_q[$];
   int            resp_t[$];

   xil_mmreq_bridge #(
      .ADDR_WIDTH    (AW),
      .TIMEOUT_CYCLES(TMO),
      .TIMEOUT_DATA  (TDAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mmreq_data(mmreq_data),
      .mmreq_wren(mmreq_wren),
      .mmreq_full(mmreq_full),
      .mmreq_open(mmreq_open),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_en    (bus_en),
      .bus_wr    (bus_wr),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata),
      .resp_data (resp_data),
      .resp_wr   (resp_wr),
      .resp_full (resp_full),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (resp_wr) begin
         resp_q.push_back(resp_data);
         resp_t.push_back(cyc);
         if (resp_full) full_viol <= full_viol + 1;
      end
      if (bus_en) begin
         en_cycles <= en_cycles + 1;
         if (prev_en && (bus_addr !== p_addr || bus_wdata !== p_wdata || bus_wr !== p_wr))
            stab_err <= stab_err + 1;
      end
      prev_en <= bus_en;
      p_addr  <= bus_addr;
      p_wdata <= bus_wdata;
      p_wr    <= bus_wr;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      mmreq_wren = 1'b1;
      mmreq_data = w;
      tick();
      mmreq_wren = 1'b0;
      mmreq_data = $urandom;
   endtask

   function automatic logic [31:0] model_w0(input logic [31:0] hdr, input logic tmo);
      return (hdr & 32'h8000_0000) | (tmo ? 32'h4000_0000 : 32'h0) | (hdr & AMASK);
   endfunction

   // One complete request; ack after dly BUS cycles, resp_full held low.
   task automatic run_req(input logic [31:0] hdr, input logic [31:0] data,
                          input logic [31:0] rdata, input int dly, input string nm);
      logic [31:0] e0, e1;
      int en0, s0, ack_cyc, n;
      resp_q.delete();
      resp_t.delete();
      en0 = en_cycles;
      s0  = stab_err;
      e0  = model_w0(hdr, 1'b0);
      e1  = hdr[31] ? rdata : data;
      send(hdr);
      send(data);
      tests_run++;
      if (bus_en !== 1'b1) begin
         tests_failed++; $display("FAIL %s bus_en: got %b want 1", nm, bus_en);
      end
      tests_run++;
      if (bus_addr !== hdr[AW-1:0]) begin
         tests_failed++; $display("FAIL %s bus_addr: got %h want %h", nm, bus_addr, hdr[AW-1:0]);
      end
      tests_run++;
      if (bus_wr !== !hdr[31]) begin
         tests_failed++; $display("FAIL %s bus_wr: got %b want %b", nm, bus_wr, !hdr[31]);
      end
      tests_run++;
      if (bus_wdata !== data) begin
         tests_failed++; $display("FAIL %s bus_wdata: got %h want %h", nm, bus_wdata, data);
      end
      repeat (dly) tick();
      bus_ack   = 1'b1;
      bus_rdata = rdata;
      ack_cyc   = cyc;
      tick();
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      n = 0;
      while (resp_q.size() < 2 && n < 20) begin
         tick();
         n++;
      end
      tests_run++;
      if (resp_q.size() != 2) begin
         tests_failed++; $display("FAIL %s resp_count: got %0d want 2", nm, resp_q.size());
      end else begin
         tests_run++;
         if (resp_q[0] !== e0) begin
            tests_failed++; $display("FAIL %s word0: got %h want %h", nm, resp_q[0], e0);
         end
         tests_run++;
         if (resp_q[1] !== e1) begin
            tests_failed++; $display("FAIL %s word1: got %h want %h", nm, resp_q[1], e1);
         end
         tests_run++;
         if (resp_t[0] != ack_cyc + 1 || resp_t[1] != ack_cyc + 2) begin
            tests_failed++;
            $display("FAIL %s resp_timing: got %0d,%0d want %0d,%0d", nm,
                     resp_t[0], resp_t[1], ack_cyc + 1, ack_cyc + 2);
         end
      end
      tests_run++;
      if (en_cycles - en0 != dly + 1) begin
         tests_failed++; $display("FAIL %s bus_en_cycles: got %0d want %0d", nm, en_cycles - en0, dly + 1);
      end
      tests_run++;
      if (stab_err != s0) begin
         tests_failed++; $display("FAIL %s bus_stability: got %0d changes want 0", nm, stab_err - s0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      tests_run++;
      if ({bus_en, bus_wr, resp_wr, busy} !== 4'b0000) begin
         tests_failed++; $display("FAIL reset_ctrl: got %b want 0000", {bus_en, bus_wr, resp_wr, busy});
      end
      tests_run++;
      if (bus_addr !== '0 || bus_wdata !== '0 || resp_data !== '0) begin
         tests_failed++;
         $display("FAIL reset_data: got addr %h wdata %h resp %h want 0", bus_addr, bus_wdata, resp_data);
      end
      tests_run++;
      if (mmreq_full !== 1'b1) begin
         tests_failed++; $display("FAIL reset_full: got %b want 1", mmreq_full);
      end
      rst = 1'b0;
      tick();
      tests_run++;
      if (mmreq_full !== 1'b0) begin
         tests_failed++; $display("FAIL post_reset_full: got %b want 0", mmreq_full);
      end
   endtask

   task automatic test_write();
      run_req(32'h0000_0010, 32'hCAFE_BABE, 32'h0BAD_0BAD, 3, "write");
   endtask

   task automatic test_read();
      run_req(32'h8000_0004, $urandom, 32'h1234_5678, 2, "read");
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++)
         run_req($urandom, $urandom, $urandom, int'($urandom_range(0, 5)), "random");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++)
         run_req($urandom, $urandom, $urandom, 0, "b2b");
   endtask

   task automatic test_timeout();
      int en0, n;
      resp_q.delete();
      en0 = en_cycles;
      send(32'h8000_0020);
      send($urandom);
`ifdef MMREQ_TIMEOUT_EN
      n = 0;
      while (resp_q.size() < 2 && n < 40) begin
         tick();
         n++;
      end
      tests_run++;
      if (en_cycles - en0 != TMO) begin
         tests_failed++; $display("FAIL timeout_en_cycles: got %0d want %0d", en_cycles - en0, TMO);
      end
      tests_run++;
      if (resp_q.size() != 2) begin
         tests_failed++; $display("FAIL timeout_resp_count: got %0d want 2", resp_q.size());
      end else begin
         tests_run++;
         if (resp_q[0] !== model_w0(32'h8000_0020, 1'b1) || resp_q[1] !== TDAT) begin
            tests_failed++;
            $display("FAIL timeout_words: got %h %h want %h %h", resp_q[0], resp_q[1],
                     model_w0(32'h8000_0020, 1'b1), TDAT);
         end
      end
      run_req(32'h8000_0020, $urandom, 32'h5A5A_1234, TMO - 1, "ack_terminal");
`else
      repeat (30) tick();
      tests_run++;
      if (bus_en !== 1'b1 || resp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL no_timeout_wait: got bus_en %b resp %0d want 1 0", bus_en, resp_q.size());
      end
      bus_ack   = 1'b1;
      bus_rdata = 32'h5A5A_1234;
      tick();
      bus_ack = 1'b0;
      n = 0;
      while (resp_q.size() < 2 && n < 20) begin
         tick();
         n++;
      end
      tests_run++;
      if (resp_q.size() != 2) begin
         tests_failed++; $display("FAIL late_ack_resp_count: got %0d want 2", resp_q.size());
      end else begin
         tests_run++;
         if (resp_q[0] !== model_w0(32'h8000_0020, 1'b0) || resp_q[1] !== 32'h5A5A_1234) begin
            tests_failed++;
            $display("FAIL late_ack_words: got %h %h want %h 5a5a1234", resp_q[0], resp_q[1],
                     model_w0(32'h8000_0020, 1'b0));
         end
      end
      tests_run++;
      if (en_cycles - en0 != 31) begin
         tests_failed++; $display("FAIL late_ack_en_cycles: got %0d want 31", en_cycles - en0);
      end
`endif
   endtask

   task automatic test_backpressure();
      logic [31:0] d;
      int f0, bad, n;
      d = $urandom;
      resp_q.delete();
      f0  = full_viol;
      bad = 0;
      send(32'h0000_0044);
      send(d);
      tick();
      resp_full = 1'b1;
      bus_ack   = 1'b1;
      tick();
      bus_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (mmreq_full !== 1'b1 || resp_wr !== 1'b0) bad++;
         tick();
      end
      tests_run++;
      if (bad != 0 || resp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL backpressure_hold: got %0d bad cycles %0d words want 0 0", bad, resp_q.size());
      end
      resp_full = 1'b0;
      n = 0;
      while (resp_q.size() < 2 && n < 20) begin
         tick();
         n++;
      end
      tests_run++;
      if (resp_q.size() != 2) begin
         tests_failed++; $display("FAIL backpressure_count: got %0d want 2", resp_q.size());
      end else begin
         tests_run++;
         if (resp_q[0] !== 32'h0000_0044 || resp_q[1] !== d) begin
            tests_failed++;
            $display("FAIL backpressure_words: got %h %h want 00000044 %h", resp_q[0], resp_q[1], d);
         end
      end
      tests_run++;
      if (full_viol != f0) begin
         tests_failed++; $display("FAIL backpressure_wr_while_full: got %0d want 0", full_viol - f0);
      end
   endtask

   task automatic test_open_drop();
      int en0;
      resp_q.delete();
      en0 = en_cycles;
      send(32'h0000_0008);
      mmreq_open = 1'b0;
      tick();
      mmreq_open = 1'b1;
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++; $display("FAIL open_drop_busy: got %b want 0", busy);
      end
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      repeat (3) tick();
      tests_run++;
      if (en_cycles != en0 || resp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL open_drop_quiet: got en %0d resp %0d want 0 0", en_cycles - en0, resp_q.size());
      end
      run_req(32'h0000_0008, $urandom, $urandom, 1, "after_drop");
   endtask

   task automatic test_reset_in_bus();
      resp_q.delete();
      send(32'h8000_0030);
      send($urandom);
      rst = 1'b1;
      tick();
      tests_run++;
      if (bus_en !== 1'b0 || mmreq_full !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_bus: got bus_en %b full %b want 0 1", bus_en, mmreq_full);
      end
      rst = 1'b0;
      #1;
      tests_run++;
      if (mmreq_full !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_release: got full %b busy %b want 0 0", mmreq_full, busy);
      end
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      repeat (5) tick();
      tests_run++;
      if (resp_q.size() != 0) begin
         tests_failed++; $display("FAIL rst_no_resp: got %0d words want 0", resp_q.size());
      end
      run_req(32'h0000_0030, $urandom, $urandom, 0, "after_rst");
   endtask

   initial begin
      rst        = 1'b1;
      mmreq_data = '0;
      mmreq_wren = 1'b0;
      mmreq_open = 1'b1;
      bus_ack    = 1'b0;
      bus_rdata  = '0;
      resp_full  = 1'b0;

      test_reset();
      test_write();
      test_read();
      test_random();
      test_back_to_back();
      test_timeout();
      test_backpressure();
      test_open_drop();
      test_reset_in_bus();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
